// File: rtl/cp0_regs.sv
// Coprocessor-0 register file with exception/ERET flush-redirect sequencer
// and the Count/Compare timer that feeds the interrupt request back to the detector.
//
// state | meaning
// IDLE  | accepting except_i / eret_i
// FLUSH | flush_o asserted, events ignored
// REDIR | redirect_o asserted with redirect_pc_o = target
module cp0_regs #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        except_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] state_i,
    input  logic [31:0] badpc_i,
    input  logic [31:0] badaddr_i,
    input  logic        eret_i,
    input  logic        mtc0_we_i,
    input  logic [4:0]  c0_addr_i,
    input  logic [31:0] c0_wdata_i,
    input  logic [5:0]  hw_int_i,
    output logic [31:0] c0_rdata_o,
    output logic        int_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        exl_o
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] target_q;
    logic        bd_q;
    logic        ti_q;
    logic [4:0]  exc_code_q;
    logic [1:0]  sw_ip_q;
    logic [5:0]  hw_ip_q;
    logic [31:0] cause_val;

    logic accept_exc;
    logic accept_eret;
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic addr_exc;

    assign accept_exc  = (state_q == IDLE) && except_i;
    assign accept_eret = (state_q == IDLE) && eret_i && !except_i;

    assign wr_count   = mtc0_we_i && (c0_addr_i == ADDR_COUNT);
    assign wr_compare = mtc0_we_i && (c0_addr_i == ADDR_COMPARE);
    assign wr_status  = mtc0_we_i && (c0_addr_i == ADDR_STATUS);
    assign wr_cause   = mtc0_we_i && (c0_addr_i == ADDR_CAUSE);
    assign wr_epc     = mtc0_we_i && (c0_addr_i == ADDR_EPC);

    // AdEL / AdES are the only codes that carry a meaningful bad address.
    assign addr_exc = (cause_i[6:2] == 5'd4) || (cause_i[6:2] == 5'd5);

    assign cause_val = {bd_q, ti_q, 14'b0, hw_ip_q[5] | ti_q, hw_ip_q[4:0],
                        sw_ip_q, 1'b0, exc_code_q, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (except_i || eret_i) state_d = FLUSH;
            FLUSH:   state_d = REDIR;
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flush_o       = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = 32'h0;
        case (state_q)
            FLUSH: flush_o = 1'b1;
            REDIR: begin
                redirect_o    = 1'b1;
                redirect_pc_o = target_q;
            end
            default: ;
        endcase
    end

    // An accepted exception owns Status/Cause/EPC for its cycle; mtc0 there is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= 32'h0040_0000;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
            bd_q       <= 1'b0;
            exc_code_q <= 5'd0;
            sw_ip_q    <= 2'b00;
            target_q   <= 32'h0;
        end else begin
            if (accept_exc) begin
                status_q   <= status_q | state_i;
                exc_code_q <= cause_i[6:2];
                target_q   <= EXC_VECTOR;
                if (!status_q[1]) begin
                    epc_q <= badpc_i;
                    bd_q  <= cause_i[31];
                end
                if (addr_exc) begin
                    badvaddr_q <= badaddr_i;
                end
            end else begin
                if (accept_eret) begin
                    status_q[1] <= 1'b0;
                    target_q    <= epc_q;
                end else if (wr_status) begin
                    status_q <= c0_wdata_i;
                end
                if (wr_cause) begin
                    sw_ip_q <= c0_wdata_i[9:8];
                end
                if (wr_epc) begin
                    epc_q <= c0_wdata_i;
                end
            end
        end
    end

    // Software writes beat the free-running increment and the compare match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            ti_q      <= 1'b0;
            hw_ip_q   <= 6'b0;
        end else begin
            hw_ip_q <= hw_int_i;
            if (wr_count) begin
                count_q <= c0_wdata_i;
            end else begin
                count_q <= count_q + 32'd1;
            end
            if (wr_compare) begin
                compare_q <= c0_wdata_i;
                ti_q      <= 1'b0;
            end else if (count_q == compare_q) begin
                ti_q <= 1'b1;
            end
        end
    end

    always_comb begin
        c0_rdata_o = 32'h0;
        case (c0_addr_i)
            ADDR_BADVADDR: c0_rdata_o = badvaddr_q;
            ADDR_COUNT:    c0_rdata_o = count_q;
            ADDR_COMPARE:  c0_rdata_o = compare_q;
            ADDR_STATUS:   c0_rdata_o = status_q;
            ADDR_CAUSE:    c0_rdata_o = cause_val;
            ADDR_EPC:      c0_rdata_o = epc_q;
            default:       c0_rdata_o = 32'h0;
        endcase
    end

    assign int_o = status_q[0] && !status_q[1] && (|(cause_val[15:8] & status_q[15:8]));
    assign exl_o = status_q[1];

endmodule

// File: tb/tb_cp0_regs.sv
// Bench for cp0_regs: table of exception/ERET events with a redirect-target
// scoreboard, plus hand sequences for timer, interrupt masking and reset.
module tb_cp0_regs;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        except_i = 1'b0;
    logic [31:0] cause_i = 32'h0;
    logic [31:0] state_i = 32'h0;
    logic [31:0] badpc_i = 32'h0;
    logic [31:0] badaddr_i = 32'h0;
    logic        eret_i = 1'b0;
    logic        mtc0_we_i = 1'b0;
    logic [4:0]  c0_addr_i = 5'd0;
    logic [31:0] c0_wdata_i = 32'h0;
    logic [5:0]  hw_int_i = 6'b0;
    logic [31:0] c0_rdata_o;
    logic        int_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        exl_o;

    cp0_regs dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .except_i      (except_i),
        .cause_i       (cause_i),
        .state_i       (state_i),
        .badpc_i       (badpc_i),
        .badaddr_i     (badaddr_i),
        .eret_i        (eret_i),
        .mtc0_we_i     (mtc0_we_i),
        .c0_addr_i     (c0_addr_i),
        .c0_wdata_i    (c0_wdata_i),
        .hw_int_i      (hw_int_i),
        .c0_rdata_o    (c0_rdata_o),
        .int_o         (int_o),
        .flush_o       (flush_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .exl_o         (exl_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          exc;
        bit          eret;
        logic [31:0] cause;
        logic [31:0] state;
        logic [31:0] badpc;
        logic [31:0] badaddr;
        bit          wr;
        bit          wr_same;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [31:0] e_epc;
        logic [31:0] e_status;
        logic [31:0] e_cause;
        logic [31:0] e_badv;
        logic [31:0] e_pc;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [31:0] sb[$];
    logic [31:0] rv;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] data);
        c0_addr_i = addr;
        #1;
        data = c0_rdata_o;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        mtc0_we_i  = 1'b1;
        c0_addr_i  = addr;
        c0_wdata_i = data;
        @(posedge clk);
        #1;
        mtc0_we_i = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic [31:0] r;
        if (v.wr && !v.wr_same) wr(v.wr_addr, v.wr_data);
        except_i  = v.exc;
        eret_i    = v.eret;
        cause_i   = v.cause;
        state_i   = v.state;
        badpc_i   = v.badpc;
        badaddr_i = v.badaddr;
        if (v.wr && v.wr_same) begin
            mtc0_we_i  = 1'b1;
            c0_addr_i  = v.wr_addr;
            c0_wdata_i = v.wr_data;
        end
        sb.push_back(v.e_pc);
        @(posedge clk);
        #1;
        except_i  = 1'b0;
        mtc0_we_i = 1'b0;
        chk($sformatf("v%0d flush", idx), 32'(flush_o), 32'd1);
        chk($sformatf("v%0d early_redir", idx), 32'(redirect_o), 32'd0);
        eret_i = 1'b1;  // stray ERET during FLUSH must be ignored
        @(posedge clk);
        #1;
        eret_i = 1'b0;
        chk($sformatf("v%0d flush_width", idx), 32'(flush_o), 32'd0);
        chk($sformatf("v%0d redir", idx), 32'(redirect_o), 32'd1);
        if (redirect_o) begin
            if (sb.size() == 0) chk($sformatf("v%0d sb_empty", idx), 32'd0, 32'd1);
            else chk($sformatf("v%0d redir_pc", idx), redirect_pc_o, sb.pop_front());
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d redir_width", idx), 32'(redirect_o), 32'd0);
        chk($sformatf("v%0d refire", idx), 32'(flush_o), 32'd0);
        chk($sformatf("v%0d pc_idle", idx), redirect_pc_o, 32'd0);
        rd(5'd14, r); chk($sformatf("v%0d epc", idx), r, v.e_epc);
        rd(5'd12, r); chk($sformatf("v%0d status", idx), r, v.e_status);
        rd(5'd13, r); chk($sformatf("v%0d cause", idx), r, v.e_cause);
        rd(5'd8, r);  chk($sformatf("v%0d badv", idx), r, v.e_badv);
        chk($sformatf("v%0d exl", idx), 32'(exl_o), {31'b0, v.e_status[1]});
    endtask

    initial begin
        int redirs;
        vec_t iv;
        vecs[0] = '{1'b1, 1'b0, 32'h30, 32'h0040_0002, 32'h0040_0100, 32'hDEAD, 1'b0, 1'b0, 5'd0, 32'h0,
                    32'h0040_0100, 32'h0040_0002, 32'h30, 32'h0, VEC};
        vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0, 32'h1234, 32'h1235, 1'b0, 1'b0, 5'd0, 32'h0,
                    32'h0040_0100, 32'h0040_0002, 32'h10, 32'h1235, VEC};
        vecs[2] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd14, 32'h0040_0200,
                    32'h0040_0200, 32'h0040_0000, 32'h10, 32'h1235, 32'h0040_0200};
        vecs[3] = '{1'b1, 1'b1, 32'h14, 32'h2, 32'h5000, 32'h6000, 1'b0, 1'b0, 5'd0, 32'h0,
                    32'h5000, 32'h0040_0002, 32'h14, 32'h6000, VEC};
        vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                    32'h5000, 32'h0040_0000, 32'h14, 32'h6000, 32'h5000};
        vecs[5] = '{1'b1, 1'b0, 32'h8000_0028, 32'h0, 32'h7000, 32'h7777, 1'b1, 1'b0, 5'd13, 32'hFFFF_FFFF,
                    32'h7000, 32'h0040_0000, 32'h8000_0328, 32'h6000, VEC};
        vecs[6] = '{1'b1, 1'b0, 32'h0C, 32'h2, 32'h8000, 32'h8888, 1'b1, 1'b1, 5'd12, 32'hFFFF_FFFF,
                    32'h8000, 32'h0040_0002, 32'h30C, 32'h6000, VEC};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst flush", 32'(flush_o), 32'd0);
        chk("rst redir", 32'(redirect_o), 32'd0);
        chk("rst pc", redirect_pc_o, 32'd0);
        chk("rst int", 32'(int_o), 32'd0);
        chk("rst exl", 32'(exl_o), 32'd0);
        rd(5'd12, rv); chk("rst status", rv, 32'h0040_0000);
        rd(5'd9, rv);  chk("rst count", rv, 32'h0);
        rd(5'd13, rv); chk("rst cause", rv, 32'h0);
        rd(5'd14, rv); chk("rst epc", rv, 32'h0);
        wr(5'd11, 32'hFFFF_0000);

        for (int i = 0; i < 7; i++) apply_vec(vecs[i], i);

        wr(5'd8, 32'hFFFF_FFFF);
        rd(5'd8, rv); chk("badv readonly", rv, 32'h6000);
        wr(5'd3, 32'h1234);
        rd(5'd3, rv); chk("unmapped", rv, 32'h0);
        wr(5'd9, 32'h100);
        rd(5'd9, rv); chk("count write wins", rv, 32'h100);

        // Timer: Count=0 then Compare=10 leaves Count=1 after that write.
        wr(5'd12, 32'h0000_8001);
        wr(5'd9, 32'h0);
        wr(5'd11, 32'd10);
        repeat (9) @(posedge clk);
        #1;
        rd(5'd13, rv); chk("ti early", {31'b0, rv[30]}, 32'd0);
        chk("int early", 32'(int_o), 32'd0);
        @(posedge clk);
        #1;
        rd(5'd13, rv);
        chk("ti set", {31'b0, rv[30]}, 32'd1);
        chk("ip7 set", {31'b0, rv[15]}, 32'd1);
        chk("timer int", 32'(int_o), 32'd1);
        wr(5'd11, 32'hFFFF_0000);
        chk("ti clr int", 32'(int_o), 32'd0);
        rd(5'd13, rv); chk("ti clr", {31'b0, rv[30]}, 32'd0);

        // Hardware interrupt masking, then EXL entry masks it.
        wr(5'd12, 32'h0000_0401);
        hw_int_i = 6'b000001;
        #1;
        chk("hw int pre", 32'(int_o), 32'd0);
        @(posedge clk);
        #1;
        chk("hw int", 32'(int_o), 32'd1);
        iv = '{1'b1, 1'b0, 32'h0, 32'h2, 32'h9000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
               32'h9000, 32'h0000_0403, 32'h0000_0700, 32'h6000, VEC};
        apply_vec(iv, 7);
        chk("exl masks int", 32'(int_o), 32'd0);
        hw_int_i = 6'b0;

        // Reset during FLUSH: no redirect afterwards.
        except_i = 1'b1;
        cause_i  = 32'h30;
        state_i  = 32'h2;
        badpc_i  = 32'hA000;
        @(posedge clk);
        #1;
        except_i = 1'b0;
        chk("mid flush", 32'(flush_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid rst flush", 32'(flush_o), 32'd0);
        redirs = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            if (redirect_o) redirs++;
        end
        rst_n = 1'b1;
        rd(5'd12, rv); chk("mid status", rv, 32'h0040_0000);
        rd(5'd9, rv);  chk("mid count", rv, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (redirect_o || flush_o) redirs++;
        end
        chk("mid no redirect", 32'(redirs), 32'd0);
        chk("sb drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_regs.md
# cp0_regs

Coprocessor-0 register file and exception sequencer that consumes the exception report (`Except`, `cause`, `state`, `badpc`, `badAddress`) from the exception detector. It latches that report into Status/Cause/EPC/BadVAddr, runs a flush-then-redirect sequence to the handler vector, and services ERET back to EPC. It also runs the Count/Compare timer and drives the interrupt request (`Int`) back to the detector, closing the loop. It sits at the pipeline commit stage beside the exception detector.

## Interface

- EXC_VECTOR, 32'hBFC0_0380, handler entry address.
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- except_i  in  1  exception report valid (detector `Except`).
- cause_i  in  32  reported cause: [31] BD, [6:2] ExcCode.
- state_i  in  32  Status bits to set on entry.
- badpc_i  in  32  faulting PC.
- badaddr_i  in  32  faulting data/fetch address.
- eret_i  in  1  ERET committing this cycle.
- mtc0_we_i  in  1  MTC0 write strobe.
- c0_addr_i  in  5  CP0 register number (read and write).
- c0_wdata_i  in  32  MTC0 data.
- hw_int_i  in  6  external interrupt lines, level-sensitive.
- c0_rdata_o  out  32  MFC0 data, combinational from c0_addr_i.
- int_o  out  1  unmasked interrupt pending (to detector `Int`).
- flush_o  out  1  pipeline flush pulse.
- redirect_o  out  1  PC redirect pulse.
- redirect_pc_o  out  32  redirect target, valid with redirect_o.
- exl_o  out  1  Status.EXL.

## Operation

- Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14). Any other address reads 0; writes to it are ignored.
- Reset values:
  - Status = 32'h0040_0000 (BEV=1).
  - All other registers = 0.
  - TI = 0, FSM = IDLE.
  - All outputs 0, except c0_rdata_o, which follows the registers.
- Writable fields:
  - Status: all 32 bits.
  - Compare: all 32 bits; a write also clears TI.
  - Count: all 32 bits.
  - EPC: all 32 bits.
  - Cause: only [9:8] (software IP).
  - BadVAddr: read-only.
- Cause composition:
  - [31] BD.
  - [30] TI.
  - [15:10] = hw_int_i registered each cycle, with [15] ORed with TI.
  - [9:8] SW IP.
  - [6:2] ExcCode.
  - All other bits 0.
- Timer:
  - Count increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
  - When Count == Compare, TI is set and stays set (sticky) until Compare is written.
- int_o = Status[0] (IE) & ~Status[1] (EXL) & |(Cause[15:8] & Status[15:8]).
- FSM states: IDLE, FLUSH, REDIR.
- IDLE with except_i=1:
  - Cause.ExcCode <= cause_i[6:2].
  - Status <= Status | state_i.
  - If the old EXL = 0: EPC <= badpc_i and Cause.BD <= cause_i[31]. If the old EXL = 1: EPC and BD are unchanged.
  - BadVAddr <= badaddr_i, only when ExcCode is 4 or 5.
  - Target <= EXC_VECTOR. Go to FLUSH.
- IDLE with eret_i=1 and except_i=0: Status[1] <= 0, target <= EPC, go to FLUSH.
- FLUSH: flush_o=1, go to REDIR.
- REDIR: redirect_o=1, redirect_pc_o = target, go to IDLE.
- In FLUSH and REDIR, except_i and eret_i are ignored. mtc0 writes are still honoured.

## Timing

- except_i/eret_i sampled at edge N:
  - Registers update at edge N.
  - flush_o is high for the cycle N..N+1.
  - redirect_o is high for the cycle N+1..N+2.
  - The next event is accepted at edge N+2.
- Each of flush_o and redirect_o is exactly one cycle wide. redirect_pc_o = 0 outside REDIR.
- except_i and eret_i in the same cycle: the exception wins and ERET is dropped.
- mtc0 in the same cycle as an accepted exception: the exception's writes win on Status, Cause and EPC. BadVAddr is read-only and is unaffected by mtc0. An mtc0 to Count or Compare still takes effect.
- mtc0 to Count in the same cycle as the increment: the write wins, and Count equals the written value after the edge.
- Compare written in the same cycle as Count == Compare: the write wins and TI stays cleared.
- Reset asserted mid-sequence: the FSM returns to IDLE immediately, outputs drop, and no redirect is issued.

## Test plan

- Overflow, EXL=0: except_i with cause_i=32'h30, badpc_i=32'h0040_0100, state_i=32'h0040_0002.
  - EPC = 32'h0040_0100, Cause[6:2] = 12, Status = 32'h0040_0002.
  - flush_o pulses next cycle; redirect_o the cycle after with redirect_pc_o = 32'hBFC0_0380.
- Nested: a second except_i (ExcCode 4, badpc_i=32'h1234, badaddr_i=32'h1235) while EXL=1.
  - EPC is unchanged, BadVAddr = 32'h1235, ExcCode = 4, redirect to the vector.
- ERET:
  - Precondition: EPC = 32'h0040_0200, EXL=1.
  - Stimulus: eret_i pulse.
  - EXL clears, flush then redirect to 32'h0040_0200.
  - except_i and eret_i together produce a vector redirect only.
- Timer: mtc0 Compare=10, Count=0.
  - Cause[30] and Cause[15] set after 10 cycles.
  - With Status = 32'h0000_8001 (IE=1, IM7=1, EXL=0): int_o=1.
  - A Compare rewrite clears TI and int_o.
- Interrupt masking: hw_int_i=6'b000001 with Status IM2=1, IE=1.
  - int_o=1 the cycle after.
  - Setting EXL via an exception forces int_o=0.
- Reset mid-sequence: assert rst_n=0 during FLUSH.
  - No redirect_o is issued; Status reads 32'h0040_0000 and Count reads 0 after release.
